// File: rtl/i2c_status_irq_ctrl.sv
// Turns the 13-bit I2C status vector into a registered status view, sticky
// rising-edge event flags, an enable mask, and one rate-limited interrupt line.
module i2c_status_irq_ctrl #(
    parameter int          HOLDOFF_CYCLES = 16,
    parameter int          CNT_W          = 5,
    parameter logic [12:0] RESET_STATUS   = 13'h0480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] next_status,
    input  logic        ie_we,
    input  logic [12:0] ie_wdata,
    input  logic        clr_we,
    input  logic [12:0] clr_wdata,
    output logic [12:0] status_out,
    output logic [12:0] event_out,
    output logic [12:0] ie_out,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [12:0]        rise_s;
    logic [12:0]        clr_mask_s;
    logic               pend_s;

    // Edge detect, clear mask and pending summary, all from registered state
    always_comb begin
        rise_s     = next_status & ~status_out;
        pend_s     = |(event_out & ie_out);
        if (clr_we) begin
            clr_mask_s = clr_wdata;
        end else begin
            clr_mask_s = 13'h0000;
        end
    end

    // Status sampling, sticky events (set beats clear) and enable register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_out <= RESET_STATUS;
            event_out  <= 13'h0000;
            ie_out     <= 13'h0000;
        end else begin
            status_out <= next_status;
            event_out  <= (event_out & ~clr_mask_s) | rise_s;
            if (ie_we) begin
                ie_out <= ie_wdata;
            end else begin
                ie_out <= ie_out;
            end
        end
    end

    // Interrupt FSM: irq is high only in ASSERT, with a minimum quiet gap afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            irq     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pend_s) begin
                        state_r <= ASSERT;
                        irq     <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        irq     <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (pend_s) begin
                        state_r <= ASSERT;
                        irq     <= 1'b1;
                    end else if (HOLDOFF_CYCLES == 0) begin
                        state_r <= IDLE;
                        irq     <= 1'b0;
                    end else begin
                        state_r <= HOLDOFF;
                        cnt_r   <= CNT_W'(HOLDOFF_CYCLES - 1);
                        irq     <= 1'b0;
                    end
                end
                HOLDOFF: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        state_r <= HOLDOFF;
                        cnt_r   <= cnt_r - CNT_W'(1);
                        irq     <= 1'b0;
                    end else if (pend_s) begin
                        state_r <= ASSERT;
                        irq     <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        irq     <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    irq     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_status_irq_ctrl.sv
// Directed bench for i2c_status_irq_ctrl: hand-computed cycle-exact expectations.
module tb_i2c_status_irq_ctrl;

    logic        clk;
    logic        rst;
    logic [12:0] next_status;
    logic        ie_we;
    logic [12:0] ie_wdata;
    logic        clr_we;
    logic [12:0] clr_wdata;
    logic [12:0] status_out;
    logic [12:0] event_out;
    logic [12:0] ie_out;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    i2c_status_irq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .next_status (next_status),
        .ie_we       (ie_we),
        .ie_wdata    (ie_wdata),
        .clr_we      (clr_we),
        .clr_wdata   (clr_wdata),
        .status_out  (status_out),
        .event_out   (event_out),
        .ie_out      (ie_out),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance into the next cycle; inputs set afterwards are sampled at the following edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; next_status = 13'h0480;
        ie_we = 1'b0; ie_wdata = 13'h0000; clr_we = 1'b0; clr_wdata = 13'h0000;
        repeat (5) tick();
        n_vec++; if (status_out !== 13'h0480) begin n_err++; $display("FAIL rst_status: got %h want %h", status_out, 13'h0480); end
        n_vec++; if (event_out !== 13'h0000) begin n_err++; $display("FAIL rst_event: got %h want %h", event_out, 13'h0000); end
        n_vec++; if (ie_out !== 13'h0000) begin n_err++; $display("FAIL rst_ie: got %h want %h", ie_out, 13'h0000); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", irq); end
        rst = 1'b0;
        repeat (3) tick();
        n_vec++; if (status_out !== 13'h0480) begin n_err++; $display("FAIL post_rst_status: got %h want %h", status_out, 13'h0480); end
        n_vec++; if (event_out !== 13'h0000) begin n_err++; $display("FAIL post_rst_event: got %h want %h", event_out, 13'h0000); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL post_rst_irq: got %b want 0", irq); end
    endtask

    task automatic test_pulse_irq();
        ie_we = 1'b1; ie_wdata = 13'h0200;
        tick();
        ie_we = 1'b0;
        next_status = 13'h0680;               // cycle N: rx_overflow pulse
        tick();
        next_status = 13'h0480;               // cycle N+1
        n_vec++; if (event_out !== 13'h0200) begin n_err++; $display("FAIL pulse_event: got %h want %h", event_out, 13'h0200); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL pulse_irq_n1: got %b want 0", irq); end
        tick();                               // cycle N+2
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL pulse_irq_n2: got %b want 1", irq); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL pulse_irq_hold%0d: got %b want 1", i, irq); end
        end
    endtask

    task automatic test_clear_holdoff();
        clr_we = 1'b1; clr_wdata = 13'h0200;  // cycle M
        tick();
        clr_we = 1'b0; clr_wdata = 13'h0000;  // cycle M+1
        n_vec++; if (event_out !== 13'h0000) begin n_err++; $display("FAIL clr_event: got %h want %h", event_out, 13'h0000); end
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL clr_irq_m1: got %b want 1", irq); end
        tick();                               // cycle M+2
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL clr_irq_m2: got %b want 0", irq); end
        tick();                               // cycle M+3
        next_status = 13'h0680;
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL clr_irq_m3: got %b want 0", irq); end
        tick();                               // cycle M+4
        next_status = 13'h0480;
        n_vec++; if (event_out !== 13'h0200) begin n_err++; $display("FAIL holdoff_event: got %h want %h", event_out, 13'h0200); end
        for (int c = 4; c <= 17; c++) begin
            n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL holdoff_irq_m%0d: got %b want 0", c, irq); end
            tick();
        end
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL holdoff_irq_m18: got %b want 1", irq); end
        clr_we = 1'b1; clr_wdata = 13'h0200;
        tick();
        clr_we = 1'b0; clr_wdata = 13'h0000;
        repeat (20) tick();
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL holdoff_drain_irq: got %b want 0", irq); end
    endtask

    task automatic test_set_beats_clear();
        next_status = 13'h1480; clr_we = 1'b1; clr_wdata = 13'h1000;
        tick();
        next_status = 13'h0480; clr_we = 1'b0; clr_wdata = 13'h0000;
        n_vec++; if (event_out !== 13'h1000) begin n_err++; $display("FAIL set_clr_event: got %h want %h", event_out, 13'h1000); end
        tick();
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL masked_irq: got %b want 0", irq); end
        clr_we = 1'b1; clr_wdata = 13'h1000;
        tick();
        clr_we = 1'b0; clr_wdata = 13'h0000;
        n_vec++; if (event_out !== 13'h0000) begin n_err++; $display("FAIL clr12_event: got %h want %h", event_out, 13'h0000); end
    endtask

    task automatic test_enable_and_level();
        ie_we = 1'b1; ie_wdata = 13'h0000;
        tick();
        ie_we = 1'b0;
        next_status = 13'h0580;               // rx_full goes and stays high
        tick();
        n_vec++; if (event_out !== 13'h0100) begin n_err++; $display("FAIL level_event: got %h want %h", event_out, 13'h0100); end
        clr_we = 1'b1; clr_wdata = 13'h0100;
        tick();
        clr_we = 1'b0; clr_wdata = 13'h0000;
        repeat (3) tick();
        n_vec++; if (event_out !== 13'h0000) begin n_err++; $display("FAIL level_once: got %h want %h", event_out, 13'h0000); end
        next_status = 13'h0480;
        tick();
        next_status = 13'h0580;
        tick();
        tick();
        n_vec++; if (event_out !== 13'h0100) begin n_err++; $display("FAIL level_rerise: got %h want %h", event_out, 13'h0100); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL ie0_irq: got %b want 0", irq); end
        ie_we = 1'b1; ie_wdata = 13'h0100;    // cycle M
        tick();
        ie_we = 1'b0;                         // cycle M+1
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL ie_irq_m1: got %b want 0", irq); end
        tick();                               // cycle M+2
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL ie_irq_m2: got %b want 1", irq); end
        ie_we = 1'b1; ie_wdata = 13'h0000;    // cycle P
        tick();
        ie_we = 1'b0;                         // cycle P+1
        n_vec++; if (ie_out !== 13'h0000) begin n_err++; $display("FAIL ie_off_reg: got %h want %h", ie_out, 13'h0000); end
        tick();                               // cycle P+2: now in HOLDOFF
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL ie_off_irq: got %b want 0", irq); end
        n_vec++; if (event_out !== 13'h0100) begin n_err++; $display("FAIL ie_off_event: got %h want %h", event_out, 13'h0100); end
    endtask

    task automatic test_reset_in_holdoff();
        tick();
        rst = 1'b1;
        #1;
        n_vec++; if (status_out !== 13'h0480) begin n_err++; $display("FAIL arst_status: got %h want %h", status_out, 13'h0480); end
        n_vec++; if (event_out !== 13'h0000) begin n_err++; $display("FAIL arst_event: got %h want %h", event_out, 13'h0000); end
        n_vec++; if (ie_out !== 13'h0000) begin n_err++; $display("FAIL arst_ie: got %h want %h", ie_out, 13'h0000); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL arst_irq: got %b want 0", irq); end
        next_status = 13'h0480;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        ie_we = 1'b1; ie_wdata = 13'h0100;
        tick();
        ie_we = 1'b0;
        next_status = 13'h0580;               // cycle N
        tick();
        n_vec++; if (event_out !== 13'h0100) begin n_err++; $display("FAIL restart_event: got %h want %h", event_out, 13'h0100); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL restart_irq_n1: got %b want 0", irq); end
        tick();                               // cycle N+2: IDLE path, no hold-off
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL restart_irq_n2: got %b want 1", irq); end
    endtask

    initial begin
        test_reset();
        test_pulse_irq();
        test_clear_holdoff();
        test_set_beats_clear();
        test_enable_and_level();
        test_reset_in_holdoff();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
